lsu_mem_stage: RTL and testbench

Memory-access stage of the three-stage pipeline. It sits directly downstream of the decode/control block and consumes its pipelined `mem_read_ppl`/`mem_wr_ppl` flags together with the execute-stage address and store data. It runs a request/acknowledge transaction on the data bus, formats load data and store byte enables, and holds the pipeline through `stall` until the access completes. Misaligned accesses are flagged and never reach the bus; a bus timeout is detected and reported.

---
 rtl/lsu_mem_stage.sv | 92 +++++++++
 tb/tb_lsu_mem_stage.sv | 132 +++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage with req/ack bus FSM, load/store formatting, misalign and timeout detection
module lsu_mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_ppl,
    input  logic        mem_wr_ppl,
    input  logic [2:0]  func3_ppl,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t      state, state_nxt;
    logic        access, is_half, is_word, mis, start, tmo_hit, uns_q;
    logic [7:0]  cnt;
    logic [1:0]  lane, size_q;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, fmt;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    always_comb begin
        access   = mem_read_ppl | mem_wr_ppl;
        is_half  = func3_ppl[1:0] == 2'b01;
        is_word  = func3_ppl[1];
        mis      = access && ((is_half && addr[0]) || (is_word && addr[1:0] != 2'b00));
        start    = state == IDLE && access && !mis;
        misalign = rst && state == IDLE && mis;
        stall    = rst && (start || state == REQ);
        tmo_hit  = state == REQ && !bus_ack && cnt == LAST;
        be_c     = is_word ? 4'b1111 : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
        wdata_c  = is_word ? store_data : is_half ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
        rbyte    = bus_rdata[{lane, 3'b000} +: 8];
        rhalf    = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        fmt      = size_q[1] ? bus_rdata :
                   size_q[0] ? {{16{rhalf[15] & !uns_q}}, rhalf} : {{24{rbyte[7] & !uns_q}}, rbyte};
        // DONE always returns to IDLE so the still-high flags cannot retrigger
        state_nxt = start ? REQ :
                    (state == REQ && (bus_ack || tmo_hit)) ? DONE :
                    state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            load_data <= '0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            cnt       <= '0;
            lane      <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus_err <= tmo_hit;
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_wr_ppl;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be_c;
                bus_wdata <= wdata_c;
                lane      <= addr[1:0];
                size_q    <= func3_ppl[1:0];
                uns_q     <= func3_ppl[2];
                cnt       <= '0;
            end else if (state == REQ) begin
                if (bus_ack || tmo_hit) begin
                    bus_req <= 1'b0;
                    if (!bus_we)
                        load_data <= bus_ack ? fmt : '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed scoreboard bench for lsu_mem_stage with TIMEOUT=4
module tb_lsu_mem_stage;
    localparam int TMO = 4;
    logic        clk = 0, rst = 0, mem_read_ppl = 0, mem_wr_ppl = 0, bus_ack = 0;
    logic [2:0]  func3_ppl = 0;
    logic [31:0] addr = 0, store_data = 0, bus_rdata = 0;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;
    int          tests = 0, fails = 0;
    logic [31:0] last_ld = 0;
    logic [31:0] q_ld[$];
    int          q_st[$], q_rq[$];

    lsu_mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .mem_read_ppl(mem_read_ppl), .mem_wr_ppl(mem_wr_ppl),
        .func3_ppl(func3_ppl), .addr(addr), .store_data(store_data), .load_data(load_data),
        .stall(stall), .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdat, input int waits,
                       input logic [31:0] exp_ld, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic exp_err);
        int  stalls = 0, reqc = 0, exp_rq;
        bit  done = 0;
        exp_rq = (waits < TMO) ? waits + 1 : TMO;
        q_ld.push_back(exp_ld);
        q_st.push_back(exp_rq + 1);
        q_rq.push_back(exp_rq);
        mem_read_ppl = rd; mem_wr_ppl = wr; func3_ppl = f3;
        addr = a; store_data = sd; bus_rdata = rdat;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (bus_req) begin
                if (reqc == 0) begin
                    chk("bus_addr", bus_addr, {a[31:2], 2'b00});
                    chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
                    chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
                    chk("bus_wdata", bus_wdata, exp_wd);
                end
                bus_ack = (reqc == waits);
                reqc++;
            end else if (!stall) begin
                done = 1;
                chk("load_data", load_data, q_ld.pop_front());
                chk("stall_cycles", stalls, q_st.pop_front());
                chk("req_cycles", reqc, q_rq.pop_front());
                chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
            end
            @(posedge clk);
            #1 bus_ack = 0;
        end
        if (!done) chk("access_done", 0, 1);
        mem_read_ppl = 0; mem_wr_ppl = 0;
        last_ld = exp_ld;
    endtask

    initial begin
        repeat (2) begin
            @(negedge clk);
            chk("rst_bus_req", {31'd0, bus_req}, 0);
            chk("rst_load_data", load_data, 0);
            chk("rst_stall", {31'd0, stall}, 0);
        end
        @(posedge clk); #1 rst = 1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_outputs", {bus_be, bus_wdata[7:0], bus_addr[7:0], 5'd0, bus_err, bus_we, bus_req, misalign, stall},
                0);
        end
        @(posedge clk); #1;
        run(1, 0, 3'b010, 32'h104, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b1111, 0, 0);
        run(1, 0, 3'b000, 32'h203, 0, 32'h80112233, 3, 32'hFFFFFF80, 4'b1000, 0, 0);
        run(1, 0, 3'b100, 32'h203, 0, 32'h80112233, 3, 32'h00000080, 4'b1000, 0, 0);
        run(1, 0, 3'b001, 32'h202, 0, 32'h80112233, 1, 32'hFFFF8011, 4'b1100, 0, 0);
        run(1, 0, 3'b101, 32'h200, 0, 32'h80112233, 0, 32'h00002233, 4'b0011, 0, 0);
        run(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'hFFFFFFFF, 0, last_ld, 4'b1100, 32'hABCDABCD, 0);
        run(0, 1, 3'b000, 32'h301, 32'h1234ABCD, 32'hFFFFFFFF, 1, last_ld, 4'b0010, 32'hCDCDCDCD, 0);
        run(1, 1, 3'b010, 32'h300, 32'h1234ABCD, 32'hFFFFFFFF, 2, last_ld, 4'b1111, 32'h1234ABCD, 0);
        mem_read_ppl = 1; func3_ppl = 3'b010; addr = 32'h102;
        #1;
        chk("misalign_flag", {31'd0, misalign}, 1);
        chk("misalign_stall", {31'd0, stall}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("misalign_no_req", {31'd0, bus_req}, 0);
            chk("misalign_ld_hold", load_data, last_ld);
        end
        @(posedge clk); #1 mem_read_ppl = 0;
        #1 chk("no_access_misalign", {31'd0, misalign}, 0);
        run(1, 0, 3'b010, 32'h400, 0, 32'h55555555, 1000, 32'h0, 4'b1111, 0, 1);
        @(negedge clk);
        chk("bus_err_one_cycle", {31'd0, bus_err}, 0);
        @(posedge clk); #1;
        run(1, 0, 3'b010, 32'h104, 0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 4'b1111, 0, 0);
        mem_read_ppl = 1; func3_ppl = 3'b010; addr = 32'h500;
        repeat (3) @(negedge clk);
        chk("pre_rst_req", {31'd0, bus_req}, 1);
        chk("pre_rst_stall", {31'd0, stall}, 1);
        rst = 0;
        #1;
        chk("rst_mid_req", {31'd0, bus_req}, 0);
        chk("rst_mid_stall", {31'd0, stall}, 0);
        chk("rst_mid_ld", load_data, 0);
        mem_read_ppl = 0;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, bus_req, stall}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
